serial_link: RTL and testbench
==============================

SERIAL_LINK -- requirements
Module: serial_link

Interface
REQ-001 SHALL have parameter CLK_DIV, default 512: system clocks per serial bit in internal-clock mode, giving 8192 Hz at 4.194304 MHz; even, >=4.
REQ-002 SHALL have port clk, input, 1: the single system clock.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port cpu_addr, input, 16: CPU bus address.
REQ-005 SHALL have port cpu_data_w, input, 8: CPU write data.
REQ-006 SHALL have port cpu_do_write, input, 1: CPU write strobe, sampled on clk.
REQ-007 SHALL have port data_r, output, 8: read data, combinational from cpu_addr.
REQ-008 SHALL have port data_active, output, 1: combinational; 1 iff cpu_addr is FF01 (SB) or FF02 (SC).
REQ-009 SHALL have port intreq_serial, output, 1: one-cycle serial interrupt request pulse.
REQ-010 SHALL have port serial_clk_out, output, 1: link clock driven in internal mode; idles high.
REQ-011 SHALL have port serial_out, output, 1: link data out, MSB first; idles high.
REQ-012 SHALL have port serial_clk_in, input, 1: asynchronous external link clock.
REQ-013 SHALL have port serial_in, input, 1: asynchronous link data in.

Function
REQ-014 SHALL return SB (shift register) as data_r at FF01, and {busy, 6'b111111, clksel} at FF02; data_r = 8'hFF when data_active = 0.
REQ-015 SHALL accept a write only on a clk edge with cpu_do_write = 1 and a matching address; a write to any other address has no effect.
REQ-016 SHALL load SB from a write to FF01 only while idle; an SB write while busy is ignored.
REQ-017 SHALL, on an SC write while idle, latch clksel = data[0] and busy = data[7]; busy = 1 enters state SHIFT with bit counter 0 and divider 0.
REQ-018 SHALL, on an SC write while busy with data[7] = 0, abort: go to IDLE, set busy = 0, raise no interrupt, drive serial_clk_out = 1, keep SB as is, and keep clksel unchanged; an SC write while busy with data[7] = 1 is ignored.
REQ-019 SHALL have two states, IDLE and SHIFT; SHIFT is left only on completion (REQ-023), abort (REQ-018) or reset.
REQ-020 SHALL, in internal mode (clksel = 1), increment the divider every clock in SHIFT, modulo CLK_DIV.
REQ-021 SHALL, in internal mode, on divider == 0 drive serial_clk_out = 0 and serial_out = SB[7] (falling event).
REQ-022 SHALL, in internal mode, on divider == CLK_DIV/2 drive serial_clk_out = 1, update SB = {SB[6:0], serial_in_sync} and increment the bit counter (rising event).
REQ-023 SHALL, on the 8th rising event, complete: go to IDLE, set busy = 0, and assert intreq_serial for exactly the following cycle.
REQ-024 SHALL, with CLK_DIV = 512 and the SC accept edge at cycle 0, place the falling events at cycles 1 + 512k and the rising events at cycles 257 + 512k, with intreq_serial high during cycle 3841 to 3842.
REQ-025 SHALL, in external mode (clksel = 0), hold serial_clk_out = 1, treat a synchronized falling edge of serial_clk_in as a falling event and a rising edge as a rising event, and apply no timeout.
REQ-026 SHALL ignore serial_clk_in edges while IDLE.
REQ-027 SHALL pass serial_in and serial_clk_in through 2-flop synchronizers, with edge detection on the synchronized clock.
REQ-028 SHALL give an abort (REQ-018) priority over a rising event that occurs in the same cycle.

Reset
REQ-029 SHALL, on reset, set state IDLE, SB = 0, busy = 0, clksel = 0, divider = 0, bit counter = 0, intreq_serial = 0, serial_clk_out = 1, serial_out = 1, and synchronizer flops = 1.
REQ-030 SHALL, on reset during SHIFT, return to IDLE next cycle with no interrupt.

Structure
REQ-031 SHALL take the SB/SC addresses (FF01/FF02) and the idle register value from the shared memory-map include header, not local literals.
REQ-032 SHALL implement both synchronizers with one sub-module, sync2 (2-flop, reset value 1), instantiated twice.

Verification
REQ-033 SHALL cover internal transfer: SB = 0xA5, SC = 0x81, serial_in = 1 -> serial_out bits 1,0,1,0,0,1,0,1 at falling events; intreq_serial at cycle 3841 only; SB reads 0xFF; SC reads 0x7F.
REQ-034 SHALL cover loopback: serial_out tied to serial_in, SB = 0x3C, SC = 0x81 -> SB reads 0x3C after completion; exactly one interrupt.
REQ-035 SHALL cover external clock: SC = 0x80, 8 serial_clk_in pulses (period 40 clocks) carrying 0x96 -> SB = 0x96, SC reads 0x7E, one interrupt; no activity on serial_clk_out.
REQ-036 SHALL cover abort: SC = 0x81, then SC = 0x01 at cycle 1000 -> busy = 0, serial_clk_out = 1, no interrupt within 5000 cycles; SB write 0x55 accepted afterwards.
REQ-037 SHALL cover busy write and reset: SB write 0x00 during SHIFT is ignored; reset asserted at cycle 2000 -> all REQ-029 values next cycle, no interrupt.
REQ-038 SHALL cover decode: addresses FF00, FF03 and C000 -> data_active = 0 and no register change on write.

Source files
------------

// File: rtl/serial_link_pkg.sv
// Serial link shared definitions.
// Register map, idle read value and FSM states.
package serial_link_pkg;

    localparam logic [15:0] ADDR_SB   = 16'hFF01;
    localparam logic [15:0] ADDR_SC   = 16'hFF02;
    localparam logic [7:0]  REG_IDLE  = 8'hFF;
    localparam logic [5:0]  SC_UNUSED = 6'b111111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/serial_link_sync2.sv
// Two-flop synchronizer for asynchronous link inputs.
// Resets to 1 so an idle-high line never looks like an edge.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_q1;
    logic r_q2;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q1 <= 1'b1;
            r_q2 <= 1'b1;
        end else begin
            r_q1 <= i_d;
            r_q2 <= r_q1;
        end
    end

    assign o_q = r_q2;

endmodule

// File: rtl/serial_link.sv
// Serial link port: SB/SC registers, 8-bit MSB-first shifter.
// Internal divided clock or synchronized external clock.
module serial_link
    import serial_link_pkg::*;
#(
    parameter int CLK_DIV = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_w,
    input  logic        cpu_do_write,
    output logic [7:0]  data_r,
    output logic        data_active,
    output logic        intreq_serial,
    output logic        serial_clk_out,
    output logic        serial_out,
    input  logic        serial_clk_in,
    input  logic        serial_in
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] HALF = DW'(CLK_DIV / 2);
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_sb;
    logic          r_clksel;
    logic [DW-1:0] r_div;
    logic [2:0]    r_bit;
    logic          r_irq;
    logic          r_sclk_out;
    logic          r_sout;
    logic          r_sclk_prev;

    logic w_sin_sync;
    logic w_sclk_sync;
    logic w_busy;
    logic w_wr_sb;
    logic w_wr_sc;
    logic w_fall;
    logic w_rise;
    logic w_abort;
    logic w_start;
    logic w_done;

    sync2 u_sync_sin (
        .clk   (clk),
        .reset (reset),
        .i_d   (serial_in),
        .o_q   (w_sin_sync)
    );

    sync2 u_sync_sclk (
        .clk   (clk),
        .reset (reset),
        .i_d   (serial_clk_in),
        .o_q   (w_sclk_sync)
    );

    assign w_busy  = (r_state == ST_SHIFT);
    assign w_wr_sb = cpu_do_write && (cpu_addr == ADDR_SB);
    assign w_wr_sc = cpu_do_write && (cpu_addr == ADDR_SC);

    assign intreq_serial  = r_irq;
    assign serial_clk_out = r_sclk_out;
    assign serial_out     = r_sout;

    // CPU read mux and address decode
    always_comb begin
        data_r      = REG_IDLE;
        data_active = 1'b0;
        if (cpu_addr == ADDR_SB) begin
            data_r      = r_sb;
            data_active = 1'b1;
        end else if (cpu_addr == ADDR_SC) begin
            data_r      = {w_busy, SC_UNUSED, r_clksel};
            data_active = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shift events, start/abort/done and next state
    always_comb begin
        w_state_nxt = r_state;
        w_fall      = 1'b0;
        w_rise      = 1'b0;
        w_abort     = 1'b0;
        w_start     = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_wr_sc && cpu_data_w[7]) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_clksel) begin
                    w_fall = (r_div == '0);
                    w_rise = (r_div == HALF);
                end else begin
                    w_fall = r_sclk_prev & ~w_sclk_sync;
                    w_rise = ~r_sclk_prev & w_sclk_sync;
                end
                if (w_wr_sc && !cpu_data_w[7]) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_rise && (r_bit == 3'd7)) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Registers, divider, shifter and link outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sb        <= 8'h00;
            r_clksel    <= 1'b0;
            r_div       <= '0;
            r_bit       <= 3'd0;
            r_irq       <= 1'b0;
            r_sclk_out  <= 1'b1;
            r_sout      <= 1'b1;
            r_sclk_prev <= 1'b1;
        end else begin
            r_sclk_prev <= w_sclk_sync;
            r_irq       <= w_done;
            if (w_wr_sb && !w_busy) begin
                r_sb <= cpu_data_w;
            end
            if (w_wr_sc && !w_busy) begin
                r_clksel <= cpu_data_w[0];
            end
            if (w_start) begin
                r_div <= '0;
                r_bit <= 3'd0;
            end else if (w_busy) begin
                if (r_clksel) begin
                    r_div <= (r_div == LAST) ? '0 : r_div + DW'(1);
                end
                if (w_abort) begin
                    r_sclk_out <= 1'b1;
                    r_sout     <= 1'b1;
                end else begin
                    if (w_fall) begin
                        if (r_clksel) begin
                            r_sclk_out <= 1'b0;
                        end
                        r_sout <= r_sb[7];
                    end
                    if (w_rise) begin
                        r_sclk_out <= 1'b1;
                        r_sb       <= {r_sb[6:0], w_sin_sync};
                        r_bit      <= r_bit + 3'd1;
                    end
                    if (w_done) begin
                        r_sout <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_link.sv
// Scoreboard bench for serial_link: stimulus queues expected link
// events, a negedge monitor pops and compares them.
module tb_serial_link;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_data_w = 8'h00;
    logic        cpu_do_write = 1'b0;
    logic [7:0]  data_r;
    logic        data_active;
    logic        intreq_serial;
    logic        serial_clk_out;
    logic        serial_out;
    logic        serial_clk_in = 1'b1;
    logic        r_sin = 1'b1;
    logic        loop_en = 1'b0;
    logic        serial_in;

    assign serial_in = loop_en ? serial_out : r_sin;

    serial_link #(.CLK_DIV(512)) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_addr       (cpu_addr),
        .cpu_data_w     (cpu_data_w),
        .cpu_do_write   (cpu_do_write),
        .data_r         (data_r),
        .data_active    (data_active),
        .intreq_serial  (intreq_serial),
        .serial_clk_out (serial_clk_out),
        .serial_out     (serial_out),
        .serial_clk_in  (serial_clk_in),
        .serial_in      (serial_in)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        b;
        int unsigned c;
    } fall_t;

    typedef struct {
        int unsigned lo;
        int unsigned hi;
    } irq_t;

    fall_t fall_q[$];
    irq_t  irq_q[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every serial_clk_out fall and every interrupt cycle
    // must match the next queued expectation.
    logic mon_prev = 1'b1;
    always @(negedge clk) begin : mon
        fall_t f;
        irq_t  q;
        if (mon_prev && !serial_clk_out) begin
            checks++;
            if (fall_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_fall: cyc %0d", cyc);
            end else begin
                f = fall_q.pop_front();
                if (serial_out !== f.b || cyc != f.c) begin
                    failures++;
                    $display("FAIL fall_event: got bit %b cyc %0d expected bit %b cyc %0d",
                             serial_out, cyc, f.b, f.c);
                end
            end
        end
        if (intreq_serial) begin
            checks++;
            if (irq_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_irq: cyc %0d", cyc);
            end else begin
                q = irq_q.pop_front();
                if (cyc < q.lo || cyc > q.hi) begin
                    failures++;
                    $display("FAIL irq_time: got cyc %0d expected %0d..%0d",
                             cyc, q.lo, q.hi);
                end
            end
        end
        mon_prev <= serial_clk_out;
    end

    task automatic wr(input logic [15:0] a, input logic [7:0] d,
                      output int unsigned acc);
        @(negedge clk);
        cpu_addr = a;
        cpu_data_w = d;
        cpu_do_write = 1'b1;
        acc = cyc + 1;
        @(posedge clk);
        #1;
        cpu_do_write = 1'b0;
        cpu_addr = 16'h0000;
    endtask

    task automatic rd(input string name, input logic [15:0] a,
                      input logic [7:0] exp, input logic act_exp);
        @(negedge clk);
        cpu_addr = a;
        #1;
        check(name, {24'h0, data_r}, {24'h0, exp});
        check({name, "_active"}, {31'h0, data_active}, {31'h0, act_exp});
        cpu_addr = 16'h0000;
    endtask

    task automatic wait_cyc(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_done(input string name, input int unsigned budget);
        int unsigned n;
        n = 0;
        while ((irq_q.size() != 0 || fall_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (irq_q.size() != 0 || fall_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout: irq pending %0d falls pending %0d expected 0",
                     name, irq_q.size(), fall_q.size());
        end
        irq_q.delete();
        fall_q.delete();
        repeat (3) @(negedge clk);
    endtask

    // Internal-clock transfer: falls at acc+1+512k carrying SB MSB first,
    // interrupt sampled at acc+3841, SB ends with the 8 bits received.
    task automatic xfer_int(input string name, input logic [7:0] sb,
                            input logic [7:0] din, input bit lb);
        int unsigned acc;
        fall_t f;
        irq_t q;
        loop_en = lb;
        r_sin = 1'b1;
        wr(16'hFF01, sb, acc);
        wr(16'hFF02, 8'h81, acc);
        for (int k = 0; k < 8; k++) begin
            f.b = sb[7-k];
            f.c = acc + 1 + 512 * k;
            fall_q.push_back(f);
        end
        q.lo = acc + 3841;
        q.hi = acc + 3841;
        irq_q.push_back(q);
        if (!lb) begin
            for (int k = 0; k < 8; k++) begin
                wait_cyc(acc + 1 + 512 * k + 4);
                r_sin = din[7-k];
            end
        end
        wait_done(name, 5000);
        loop_en = 1'b0;
        rd({name, "_sb"}, 16'hFF01, lb ? sb : din, 1'b1);
        rd({name, "_sc"}, 16'hFF02, 8'h7F, 1'b1);
    endtask

    // External-clock transfer: 8 pulses of period 40 clocks on
    // serial_clk_in, data changes with each falling edge.
    task automatic xfer_ext(input string name, input logic [7:0] sb,
                            input logic [7:0] din);
        int unsigned acc;
        irq_t q;
        wr(16'hFF01, sb, acc);
        wr(16'hFF02, 8'h80, acc);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            serial_clk_in = 1'b0;
            r_sin = din[7-k];
            repeat (20) @(negedge clk);
            check({name, "_out"}, {31'h0, serial_out}, {31'h0, sb[7-k]});
            if (k == 7) begin
                q.lo = cyc + 2;
                q.hi = cyc + 4;
                irq_q.push_back(q);
            end
            serial_clk_in = 1'b1;
            repeat (19) @(negedge clk);
        end
        wait_done(name, 200);
        rd({name, "_sb"}, 16'hFF01, din, 1'b1);
        rd({name, "_sc"}, 16'hFF02, 8'h7E, 1'b1);
    endtask

    initial begin
        int unsigned acc;
        fall_t f;
        logic [7:0] v;
        logic [7:0] w;
        logic [15:0] bad [3];

        bad[0] = 16'hFF00;
        bad[1] = 16'hFF03;
        bad[2] = 16'hC000;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        rd("rst_sb", 16'hFF01, 8'h00, 1'b1);
        rd("rst_sc", 16'hFF02, 8'h7E, 1'b1);
        check("rst_irq", {31'h0, intreq_serial}, 32'h0);
        check("rst_sclk", {31'h0, serial_clk_out}, 32'h1);
        check("rst_sout", {31'h0, serial_out}, 32'h1);

        v = 8'($urandom);
        wr(16'hFF01, v, acc);
        for (int i = 0; i < 3; i++) begin
            rd("dec_idle", bad[i], 8'hFF, 1'b0);
            wr(bad[i], 8'($urandom) | 8'h80, acc);
            rd("dec_sb", 16'hFF01, v, 1'b1);
            rd("dec_sc", 16'hFF02, 8'h7E, 1'b1);
        end
        check("dec_no_irq", {31'h0, intreq_serial}, 32'h0);

        xfer_int("int_a5", 8'hA5, 8'hFF, 1'b0);
        xfer_int("loop_3c", 8'h3C, 8'h00, 1'b1);
        xfer_ext("ext_96", 8'($urandom), 8'h96);
        xfer_ext("ext_rnd", 8'($urandom), 8'($urandom));

        r_sin = 1'b1;
        v = 8'($urandom);
        wr(16'hFF01, v, acc);
        wr(16'hFF02, 8'h81, acc);
        for (int k = 0; k < 2; k++) begin
            f.b = v[7-k];
            f.c = acc + 1 + 512 * k;
            fall_q.push_back(f);
        end
        wait_cyc(acc + 998);
        wr(16'hFF02, 8'h01, acc);
        check("abort_sclk", {31'h0, serial_clk_out}, 32'h1);
        rd("abort_sc", 16'hFF02, 8'h7F, 1'b1);
        rd("abort_sb", 16'hFF01, {v[5:0], 2'b11}, 1'b1);
        repeat (5000) @(negedge clk);
        check("abort_falls_left", fall_q.size(), 32'h0);
        wr(16'hFF01, 8'h55, acc);
        rd("abort_sb_wr", 16'hFF01, 8'h55, 1'b1);

        v = 8'($urandom);
        wr(16'hFF01, v, acc);
        wr(16'hFF02, 8'h81, acc);
        for (int k = 0; k < 4; k++) begin
            f.b = v[7-k];
            f.c = acc + 1 + 512 * k;
            fall_q.push_back(f);
        end
        wait_cyc(acc + 298);
        wr(16'hFF01, 8'h00, w);
        wait_cyc(acc + 1990);
        rd("busy_sb", 16'hFF01, {v[3:0], 4'hF}, 1'b1);
        wait_cyc(acc + 1999);
        reset = 1'b1;
        @(negedge clk);
        cpu_addr = 16'hFF01;
        #1;
        check("rst2_sb", {24'h0, data_r}, 32'h00);
        cpu_addr = 16'hFF02;
        #1;
        check("rst2_sc", {24'h0, data_r}, 32'h7E);
        check("rst2_irq", {31'h0, intreq_serial}, 32'h0);
        check("rst2_sclk", {31'h0, serial_clk_out}, 32'h1);
        check("rst2_sout", {31'h0, serial_out}, 32'h1);
        check("rst2_falls_left", fall_q.size(), 32'h0);
        cpu_addr = 16'h0000;
        reset = 1'b0;
        repeat (4000) @(negedge clk);

        for (int i = 0; i < 2; i++) begin
            xfer_int("int_rnd", 8'($urandom), 8'($urandom), 1'b0);
        end

        check("end_falls_left", fall_q.size(), 32'h0);
        check("end_irqs_left", irq_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
